// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths,
// FSM state encoding and the requester id type.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t RESP   = 2'd2;

    // Requester id: 0 = datapath load/store, 1 = loader/DMA port.
    typedef logic req_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the pointer holder wins a tie, a lone
// request wins regardless of the pointer.
// Ports: valid (request vector), ptr (current priority holder),
//        grant_valid/grant_id (pick), ptr_next (pointer after a grant).
import dmem_pkg::*;

module rr_arb2 (
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output logic       grant_valid,
    output req_id_t    grant_id,
    output req_id_t    ptr_next
);

    always_comb begin
        grant_valid = |valid;
        if (&valid) begin
            grant_id = ptr;
        end else begin
            grant_id = valid[1];
        end
        // After any grant the other port holds priority.
        ptr_next = ~grant_id;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between two requesters with a fixed
// IDLE -> ACCESS -> RESP sequence and round-robin arbitration.
// Ports: clk/reset (sync, active high); req0_*/req1_* request inputs and
//        ready pulses; resp0_*/resp1_* completion pulses with load data;
//        mem_* strobes to the memory and mem_ReadData back from it.
import dmem_pkg::*;

module dmem_arbiter #(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              mem_MemWrite,
    output logic              mem_MemRead,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_WriteData,
    input  logic [DATA_W-1:0] mem_ReadData
);

    state_t            state;
    req_id_t           id_q;
    req_id_t           ptr_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        ready_q;
    logic [1:0]        resp_q;

    logic              grant_valid;
    req_id_t           grant_id;
    req_id_t           ptr_next;
    logic              in_access;

    rr_arb2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .ptr_next    (ptr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            ptr_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= '0;
            resp_q  <= '0;
        end else begin
            ready_q <= '0;
            resp_q  <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        id_q             <= grant_id;
                        wr_q             <= grant_id ? req1_write : req0_write;
                        addr_q           <= grant_id ? req1_addr  : req0_addr;
                        wdata_q          <= grant_id ? req1_wdata : req0_wdata;
                        ready_q[grant_id] <= 1'b1;
                        ptr_q            <= ptr_next;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q      <= wr_q ? '0 : mem_ReadData;
                    resp_q[id_q] <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ACCESS);

    // Gating with reset keeps a store from committing on the reset edge.
    assign mem_MemWrite  = in_access & wr_q & ~reset;
    assign mem_MemRead   = in_access & ~wr_q;
    assign mem_Addr      = in_access ? addr_q  : '0;
    assign mem_WriteData = in_access ? wdata_q : '0;

    assign req0_ready  = ready_q[0];
    assign req1_ready  = ready_q[1];
    assign resp0_valid = resp_q[0];
    assign resp1_valid = resp_q[1];
    assign resp0_rdata = resp_q[0] ? rdata_q : '0;
    assign resp1_rdata = resp_q[1] ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a 32-word memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_write, req0_ready, resp0_valid;
    logic [31:0] req0_addr, req0_wdata, resp0_rdata;
    logic        req1_valid, req1_write, req1_ready, resp1_valid;
    logic [31:0] req1_addr, req1_wdata, resp1_rdata;
    logic        mem_MemWrite, mem_MemRead;
    logic [31:0] mem_Addr, mem_WriteData, mem_ReadData;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_write    (req0_write),
        .req0_addr     (req0_addr),
        .req0_wdata    (req0_wdata),
        .req0_ready    (req0_ready),
        .resp0_valid   (resp0_valid),
        .resp0_rdata   (resp0_rdata),
        .req1_valid    (req1_valid),
        .req1_write    (req1_write),
        .req1_addr     (req1_addr),
        .req1_wdata    (req1_wdata),
        .req1_ready    (req1_ready),
        .resp1_valid   (resp1_valid),
        .resp1_rdata   (resp1_rdata),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_Addr      (mem_Addr),
        .mem_WriteData (mem_WriteData),
        .mem_ReadData  (mem_ReadData)
    );

    logic [31:0] mem [32];
    assign mem_ReadData = mem[mem_Addr[4:0]];
    always @(posedge clk) begin
        if (mem_MemWrite) mem[mem_Addr[4:0]] <= mem_WriteData;
    end

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[9];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_req(input logic port, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
        if (port) begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end
    endtask

    // Scoreboard side: every response is matched against the oldest grant.
    always @(negedge clk) begin
        if (!reset) begin
            chk("overlap", {30'b0, req0_ready & req1_ready,
                            resp0_valid & resp1_valid}, 32'h0);
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", {31'b0, resp1_valid}, {31'b0, e.port});
                    chk("resp_rdata", e.port ? resp1_rdata : resp0_rdata,
                        e.rdata);
                end
            end
        end
    end

    task automatic issue(input logic port, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata);
        int n;
        set_req(port, 1'b1, wr, a, d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? req1_ready : req0_ready) && n < 10);
        chk("ready_latency", 32'(n), 32'd2);
        if (n < 10) begin
            sb.push_back('{port, exp_rdata});
            chk("strobe_write", {31'b0, mem_MemWrite}, {31'b0, wr});
            chk("strobe_read", {31'b0, mem_MemRead}, {31'b0, ~wr});
            chk("strobe_addr", mem_Addr, a);
        end
        @(posedge clk);
        #1 set_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? resp1_valid : resp0_valid) && n < 10);
        chk("resp_latency", 32'(n), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g, last, n;
        logic p;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        tbl[0] = '{1'b0, 1'b1, 32'h3,        32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'h3,        32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'h25,       32'h12345678, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h5,        32'h0,        32'h12345678};
        tbl[4] = '{1'b1, 1'b0, 32'h3,        32'h0,        32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b1, 32'h1F,       32'hCAFEF00D, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hCAFEF00D};
        tbl[7] = '{1'b0, 1'b1, 32'h1,        32'h11111111, 32'h0};
        tbl[8] = '{1'b1, 1'b1, 32'h2,        32'h22222222, 32'h0};
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {26'b0, req0_ready, req1_ready, resp0_valid,
                          resp1_valid, mem_MemRead, mem_MemWrite}, 32'h0);
        chk("rst_addr", mem_Addr, 32'h0);
        chk("rst_wdata", mem_WriteData, 32'h0);
        chk("rst_rdata", resp0_rdata | resp1_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                  tbl[i].exp);
        end

        // Both ports held valid straight out of reset: strict alternation.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h2, 32'h0);
        g = 0;
        last = 0;
        for (int c = 0; c < 40 && g < 6; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                p = req1_ready;
                chk("grant_order", {31'b0, p}, 32'(g % 2));
                if (g == 0) chk("first_grant", 32'(c), 32'd1);
                else chk("grant_gap", 32'(c - last), 32'd3);
                last = c;
                sb.push_back('{p, p ? 32'h22222222 : 32'h11111111});
                g++;
            end
        end
        chk("grant_count", 32'(g), 32'd6);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;

        // Reset lands while a store to addr 7 is in ACCESS.
        set_req(1'b0, 1'b1, 1'b1, 32'h7, 32'hAA);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_ready && n < 10);
        chk("rst_store_ready", 32'(n), 32'd2);
        reset = 1'b1;
        #1;
        chk("store_gated", {31'b0, mem_MemWrite}, 32'h0);
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_flags", {26'b0, req0_ready, req1_ready, resp0_valid,
                               resp1_valid, mem_MemRead, mem_MemWrite},
            32'h0);
        chk("post_rst_addr", mem_Addr | mem_WriteData, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 32'h7, 32'h0, 32'h0);

        // Quiet bus: nothing may move.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {26'b0, req0_ready, req1_ready, resp0_valid,
                               resp1_valid, mem_MemRead, mem_MemWrite},
                32'h0);
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
